// File: rtl/rattlesnake_mtimer_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rattlesnake_mtimer_bus_bridge: data-port front end for the machine timer |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module rattlesnake_mtimer_bus_bridge #(
  parameter int                   XLEN       = 32,
  parameter int                   ADDR_BITS  = 32,
  parameter logic [ADDR_BITS-1:0] TIMER_BASE = 32'h2000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_re,
  input  logic                 mem_we,
  input  logic [XLEN-1:0]      mem_wdata,
  output logic                 mem_ready,
  output logic                 mem_err,
  output logic [XLEN-1:0]      mem_rdata,
  output logic                 load_mtimecmp_low,
  output logic                 load_mtimecmp_high,
  output logic [XLEN-1:0]      mtimecmp_write_data,
  output logic [1:0]           reg_read_addr,
  input  logic [XLEN-1:0]      reg_read_data,
  input  logic                 timer_triggered,
  input  logic                 mie_mtie,
  output logic                 mtip
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_SEL = 2'd1,
    RD_CAP = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] PARK_ADDR = 2'b10;

  state_t          state_q, state_d;
  logic            mem_ready_q, mem_ready_d;
  logic            mem_err_q, mem_err_d;
  logic [XLEN-1:0] mem_rdata_q, mem_rdata_d;
  logic            ld_lo_q, ld_lo_d;
  logic            ld_hi_q, ld_hi_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      rd_addr_q, rd_addr_d;
  logic            mtip_q, mtip_d;

  logic hit, req, bad;

  assign hit = (mem_addr[ADDR_BITS-1:4] == TIMER_BASE[ADDR_BITS-1:4]);
  assign req = mem_re | mem_we;
  // mtime is read-only from the bus; only the compare words accept writes.
  assign bad = (mem_re & mem_we) | (mem_addr[1:0] != 2'b00) | (mem_we & ~mem_addr[3]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= '0;
      ld_lo_q     <= 1'b0;
      ld_hi_q     <= 1'b0;
      wdata_q     <= '0;
      rd_addr_q   <= PARK_ADDR;
      mtip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
      ld_lo_q     <= ld_lo_d;
      ld_hi_q     <= ld_hi_d;
      wdata_q     <= wdata_d;
      rd_addr_q   <= rd_addr_d;
      mtip_q      <= mtip_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    ld_lo_d     = 1'b0;
    ld_hi_d     = 1'b0;
    wdata_d     = wdata_q;
    rd_addr_d   = rd_addr_q;
    mtip_d      = timer_triggered & mie_mtie;

    if (sync_reset) begin
      state_d     = IDLE;
      mem_rdata_d = '0;
      wdata_d     = '0;
      rd_addr_d   = PARK_ADDR;
      mtip_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit && req) begin
            if (bad) begin
              state_d     = DONE;
              mem_ready_d = 1'b1;
              mem_err_d   = 1'b1;
              mem_rdata_d = '0;
            end else if (mem_we) begin
              state_d     = DONE;
              mem_ready_d = 1'b1;
              ld_lo_d     = ~mem_addr[2];
              ld_hi_d     = mem_addr[2];
              wdata_d     = mem_wdata;
            end else begin
              state_d   = RD_SEL;
              rd_addr_d = mem_addr[3:2];
            end
          end
        end
        // Select is presented for a single cycle so the mtime-high snapshot
        // is taken on the same edge that registers the low word.
        RD_SEL: begin
          state_d   = RD_CAP;
          rd_addr_d = PARK_ADDR;
        end
        RD_CAP: begin
          state_d     = DONE;
          mem_rdata_d = reg_read_data;
          mem_ready_d = 1'b1;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign mem_ready           = mem_ready_q;
  assign mem_err             = mem_err_q;
  assign mem_rdata           = mem_rdata_q;
  assign load_mtimecmp_low   = ld_lo_q;
  assign load_mtimecmp_high  = ld_hi_q;
  assign mtimecmp_write_data = wdata_q;
  assign reg_read_addr       = rd_addr_q;
  assign mtip                = mtip_q;

endmodule
`default_nettype wire

// File: tb/tb_rattlesnake_mtimer_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rattlesnake_mtimer_bus_bridge: directed bench with a small timer model|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_rattlesnake_mtimer_bus_bridge;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_reset;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_err;
  logic [31:0] mem_rdata;
  logic        load_mtimecmp_low;
  logic        load_mtimecmp_high;
  logic [31:0] mtimecmp_write_data;
  logic [1:0]  reg_read_addr;
  logic [31:0] reg_read_data = 32'h0;
  logic        timer_triggered;
  logic        mie_mtie;
  logic        mtip;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rattlesnake_mtimer_bus_bridge #(
    .XLEN       (32),
    .ADDR_BITS  (32),
    .TIMER_BASE (BASE)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .sync_reset          (sync_reset),
    .mem_addr            (mem_addr),
    .mem_re              (mem_re),
    .mem_we              (mem_we),
    .mem_wdata           (mem_wdata),
    .mem_ready           (mem_ready),
    .mem_err             (mem_err),
    .mem_rdata           (mem_rdata),
    .load_mtimecmp_low   (load_mtimecmp_low),
    .load_mtimecmp_high  (load_mtimecmp_high),
    .mtimecmp_write_data (mtimecmp_write_data),
    .reg_read_addr       (reg_read_addr),
    .reg_read_data       (reg_read_data),
    .timer_triggered     (timer_triggered),
    .mie_mtie            (mie_mtie),
    .mtip                (mtip)
  );

  // Timer model: free-running mtime, high word snapshotted while select is 00.
  logic [63:0] mtime       = 64'h0;
  logic [63:0] mtimecmp    = 64'h0;
  logic [31:0] snap_hi     = 32'h0;
  logic [63:0] mtime_at_lo = 64'h0;
  logic        pre_en      = 1'b0;
  logic [63:0] pre_val     = 64'h0;

  always @(posedge clk) begin
    if (pre_en) mtime <= pre_val;
    else        mtime <= mtime + 64'd1;
    if (reg_read_addr == 2'b00) begin
      snap_hi     <= mtime[63:32];
      mtime_at_lo <= mtime;
    end
    case (reg_read_addr)
      2'b00:   reg_read_data <= mtime[31:0];
      2'b01:   reg_read_data <= snap_hi;
      2'b10:   reg_read_data <= mtimecmp[31:0];
      default: reg_read_data <= mtimecmp[63:32];
    endcase
    if (load_mtimecmp_low)  mtimecmp[31:0]  <= mtimecmp_write_data;
    if (load_mtimecmp_high) mtimecmp[63:32] <= mtimecmp_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request sampled at the next edge k; returns 1 ns into cycle k+1.
  task automatic issue(input logic [31:0] a, input logic re, input logic we, input logic [31:0] d);
    step();
    mem_addr  = a;
    mem_re    = re;
    mem_we    = we;
    mem_wdata = d;
    step();
    mem_re    = 1'b0;
    mem_we    = 1'b0;
  endtask

  task automatic do_rd(input string tag, input logic [31:0] a, input logic [1:0] code,
                       output logic [31:0] got);
    issue(a, 1'b1, 1'b0, 32'h0);
    chk({tag, "_sel_addr"}, {30'h0, reg_read_addr}, {30'h0, code});
    chk({tag, "_rdy_k1"}, {31'h0, mem_ready}, 32'h0);
    step();
    chk({tag, "_rdy_k2"}, {31'h0, mem_ready}, 32'h0);
    step();
    chk({tag, "_rdy_k3"}, {31'h0, mem_ready}, 32'h1);
    chk({tag, "_err_k3"}, {31'h0, mem_err}, 32'h0);
    got = mem_rdata;
    step();
    chk({tag, "_rdy_k4"}, {31'h0, mem_ready}, 32'h0);
    chk({tag, "_park"}, {30'h0, reg_read_addr}, 32'h2);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_rdy"},   {31'h0, mem_ready}, 32'h1);
    chk({tag, "_err"},   {31'h0, mem_err}, 32'h1);
    chk({tag, "_rdata"}, mem_rdata, 32'h0);
    chk({tag, "_strb"},  {30'h0, load_mtimecmp_high, load_mtimecmp_low}, 32'h0);
    chk({tag, "_addr"},  {30'h0, reg_read_addr}, 32'h2);
    step();
    chk({tag, "_rdy_off"}, {31'h0, mem_ready}, 32'h0);
  endtask

  logic [31:0] rd_lo, rd_hi;

  initial begin
    reset_n         = 1'b0;
    sync_reset      = 1'b0;
    mem_addr        = 32'h0;
    mem_re          = 1'b0;
    mem_we          = 1'b0;
    mem_wdata       = 32'h0;
    timer_triggered = 1'b0;
    mie_mtie        = 1'b0;

    repeat (3) step();
    chk("rst_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_err",   {31'h0, mem_err}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_strb",  {30'h0, load_mtimecmp_high, load_mtimecmp_low}, 32'h0);
    chk("rst_wdata", mtimecmp_write_data, 32'h0);
    chk("rst_addr",  {30'h0, reg_read_addr}, 32'h2);
    chk("rst_mtip",  {31'h0, mtip}, 32'h0);
    reset_n = 1'b1;

    // mtimecmp low write
    issue(BASE + 32'h8, 1'b0, 1'b1, 32'h0000_1000);
    chk("wlo_strb_lo", {31'h0, load_mtimecmp_low}, 32'h1);
    chk("wlo_strb_hi", {31'h0, load_mtimecmp_high}, 32'h0);
    chk("wlo_wdata",   mtimecmp_write_data, 32'h0000_1000);
    chk("wlo_rdy",     {31'h0, mem_ready}, 32'h1);
    chk("wlo_err",     {31'h0, mem_err}, 32'h0);
    step();
    chk("wlo_strb_off", {31'h0, load_mtimecmp_low}, 32'h0);
    chk("wlo_rdy_off",  {31'h0, mem_ready}, 32'h0);

    // mtimecmp high write then read-back of both halves
    issue(BASE + 32'hC, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("whi_strb", {30'h0, load_mtimecmp_high, load_mtimecmp_low}, 32'h2);
    chk("whi_rdy",  {31'h0, mem_ready}, 32'h1);
    step();
    do_rd("rd_c", BASE + 32'hC, 2'b11, rd_hi);
    chk("rd_c_data", rd_hi, 32'hDEAD_BEEF);
    do_rd("rd_8", BASE + 32'h8, 2'b10, rd_lo);
    chk("rd_8_data", rd_lo, 32'h0000_1000);

    // Coherent mtime read across a low-word carry
    pre_val = 64'h0000_0007_FFFF_FFFC;
    pre_en  = 1'b1;
    step();
    pre_en  = 1'b0;
    do_rd("rd_0", BASE + 32'h0, 2'b00, rd_lo);
    do_rd("rd_4", BASE + 32'h4, 2'b01, rd_hi);
    chk("mtime_lo", rd_lo, mtime_at_lo[31:0]);
    chk("mtime_hi", rd_hi, 32'h0000_0007);
    chk("mtime_lo_near_wrap", {31'h0, (rd_lo >= 32'hFFFF_FFF0)}, 32'h1);
    chk("idle_park", {30'h0, reg_read_addr}, 32'h2);

    // Error completions
    issue(BASE + 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    chk_err("e_wr0");
    issue(BASE + 32'h4, 1'b0, 1'b1, 32'h1234_5678);
    chk_err("e_wr4");
    issue(BASE + 32'h2, 1'b1, 1'b0, 32'h0);
    chk_err("e_mis");
    issue(BASE + 32'hA, 1'b0, 1'b1, 32'h5555_5555);
    chk_err("e_miswr");
    issue(BASE + 32'h8, 1'b1, 1'b1, 32'hAAAA_AAAA);
    chk_err("e_rewe");

    // Window miss: nothing happens
    issue(BASE + 32'h10, 1'b0, 1'b1, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      chk("miss_rdy",  {31'h0, mem_ready}, 32'h0);
      chk("miss_strb", {30'h0, load_mtimecmp_high, load_mtimecmp_low}, 32'h0);
      step();
    end
    issue(BASE - 32'h4, 1'b1, 1'b0, 32'h0);
    chk("miss_rd_addr", {30'h0, reg_read_addr}, 32'h2);
    step();
    step();
    chk("miss_rd_rdy", {31'h0, mem_ready}, 32'h0);

    // mtip qualification
    timer_triggered = 1'b1;
    mie_mtie        = 1'b0;
    step();
    chk("mtip_off", {31'h0, mtip}, 32'h0);
    mie_mtie = 1'b1;
    chk("mtip_lag_rise", {31'h0, mtip}, 32'h0);
    step();
    chk("mtip_on", {31'h0, mtip}, 32'h1);
    mie_mtie = 1'b0;
    chk("mtip_lag_fall", {31'h0, mtip}, 32'h1);
    step();
    chk("mtip_off2", {31'h0, mtip}, 32'h0);
    timer_triggered = 1'b0;

    // sync_reset during RD_CAP aborts the read
    issue(BASE + 32'hC, 1'b1, 1'b0, 32'h0);
    chk("abort_sel", {30'h0, reg_read_addr}, 32'h3);
    step();
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    chk("abort_rdy",  {31'h0, mem_ready}, 32'h0);
    chk("abort_addr", {30'h0, reg_read_addr}, 32'h2);
    step();
    chk("abort_rdy2", {31'h0, mem_ready}, 32'h0);
    do_rd("rd_after", BASE + 32'hC, 2'b11, rd_hi);
    chk("rd_after_data", rd_hi, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rattlesnake_mtimer_bus_bridge.md
Name: rattlesnake_mtimer_bus_bridge

Overview:
Memory-mapped front end that drives the machine timer's control side from the core's data-memory port. It decodes word accesses to a 16-byte timer window into mtimecmp load strobes and a read-address/capture sequence, and returns read data with a ready/error handshake. It also qualifies the timer's trigger with the MTIE enable to produce the registered MTIP level for the trap logic.

Parameters:
XLEN, 32, data width; must match the timer.
ADDR_BITS, 32, width of mem_addr.
TIMER_BASE, 32'h2000_0000, byte base of the window; must be 16-byte aligned.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
sync_reset  input  1  synchronous reset, same effect as reset_n but sampled on clk
mem_addr  input  ADDR_BITS  byte address, valid with mem_re/mem_we
mem_re  input  1  read request, single-cycle pulse
mem_we  input  1  write request, single-cycle pulse
mem_wdata  input  XLEN  write data
mem_ready  output  1  one-cycle completion pulse for a window hit
mem_err  output  1  error flag, valid only with mem_ready
mem_rdata  output  XLEN  read data, valid with mem_ready
load_mtimecmp_low  output  1  one-cycle strobe to the timer
load_mtimecmp_high  output  1  one-cycle strobe to the timer
mtimecmp_write_data  output  XLEN  data for the load strobes
reg_read_addr  output  2  timer register select
reg_read_data  input  XLEN  registered timer read data, valid 1 cycle after reg_read_addr
timer_triggered  input  1  timer compare level
mie_mtie  input  1  machine timer interrupt enable
mtip  output  1  registered timer_triggered & mie_mtie

Behaviour:
- Reset (reset_n low or sync_reset high): state IDLE. mem_ready=0, mem_err=0, mem_rdata=0, both load strobes=0, mtimecmp_write_data=0, reg_read_addr=2'b10, mtip=0.
- Hit: mem_addr[ADDR_BITS-1:4]==TIMER_BASE[ADDR_BITS-1:4]. A miss gets no response; all outputs stay idle.
- Offset map (mem_addr[3:0]):
  - 0x0: mtime low; read selects addr 2'b00.
  - 0x4: mtime high; read selects addr 2'b01.
  - 0x8: mtimecmp low; read selects addr 2'b10, write pulses load_mtimecmp_low.
  - 0xC: mtimecmp high; read selects addr 2'b11, write pulses load_mtimecmp_high.
- Park rule: reg_read_addr idles at 2'b10, never 2'b00. The timer snapshots mtime high only while the address is 2'b00, so reading 0x0 then 0x4 yields a coherent 64-bit value.
- FSM states: IDLE, RD_SEL, RD_CAP, DONE. Requests are sampled only in IDLE; mem_re/mem_we in any other state are ignored.
- Write hit, valid (offset 0x8/0xC, mem_addr[1:0]==0, mem_re=0), request sampled at edge k:
  - In cycle k+1 the matching strobe=1, mtimecmp_write_data=mem_wdata, mem_ready=1, mem_err=0.
  - State goes IDLE->DONE->IDLE.
  - Write latency: 1 cycle.
- Read hit, valid, sampled at edge k:
  - Cycle k+1 (RD_SEL): reg_read_addr=selected code.
  - Cycle k+2 (RD_CAP): reg_read_data is valid; captured into mem_rdata at the end of the cycle.
  - Cycle k+3 (DONE): mem_ready=1, mem_err=0.
  - Then reg_read_addr returns to 2'b10 and the state to IDLE.
  - Read latency: 3 cycles.
- Error hits: completed like writes (mem_ready at k+1, mem_err=1, mem_rdata=0, no strobe, reg_read_addr unchanged). Error cases:
  - write to offset 0x0 or 0x4;
  - mem_addr[1:0]!=0;
  - mem_re and mem_we both high.
- Strobes are never asserted together. Each strobe is exactly one cycle per accepted write.
- mtip: registered one cycle after (timer_triggered & mie_mtie). It follows the timer's clear caused by a load with the same 1-cycle lag.
- sync_reset during RD_SEL/RD_CAP aborts the access: no mem_ready, state IDLE. Asynchronous reset_n behaves the same.

Test Plan:
- Write 0x0000_1000 to BASE+0x8 -> next cycle load_mtimecmp_low=1 for 1 cycle, mtimecmp_write_data=0x1000, mem_ready=1, mem_err=0.
- Write 0xDEAD_BEEF to BASE+0xC, then read BASE+0xC -> read mem_ready 3 cycles after request, mem_rdata=0xDEADBEEF.
- With the timer running, read BASE+0x0 then BASE+0x4 -> the 64-bit concatenation equals the mtime value at the low read, even across a low-word carry (preload mtime near 0xFFFF_FFFF); reg_read_addr never 2'b00 while idle.
- Write to BASE+0x0, access BASE+0x2, and mem_re&mem_we together -> each gives mem_ready with mem_err=1, no strobes, mem_rdata=0.
- timer_triggered=1 with mie_mtie toggling 0->1->0 -> mtip follows with 1-cycle lag; address outside the window -> no mem_ready.
- Assert sync_reset in RD_CAP -> no mem_ready; reg_read_addr=2'b10; the next read completes normally.
